// File: rtl/commit_trace_buffer_pkg.sv
// rtl/commit_trace_buffer_pkg.sv - shared state encoding and record layout for the commit trace buffer
//
// Shared by commit_trace_buffer and its bench.
//   trace_state_e  : 2-bit capture FSM encoding, visible on trace_state.
//   TRACE_*_LSB    : bit offsets of the fields in a packed trace record
//                    {pc, opcode, wr_addr, wr_data}, wr_data in the LSBs.
//                    Offsets past the data field depend on the datapath width,
//                    so they are functions of word_size.
package commit_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TRACE_IDLE    = 2'd0,
        TRACE_ARMED   = 2'd1,
        TRACE_CAPTURE = 2'd2,
        TRACE_DONE    = 2'd3
    } trace_state_e;

    localparam int TRACE_DATA_LSB = 0;

    function automatic int trace_addr_lsb(input int word_size);
        return word_size;
    endfunction

    function automatic int trace_op_lsb(input int word_size);
        return word_size + 5;
    endfunction

    function automatic int trace_pc_lsb(input int word_size);
        return word_size + 11;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - parameterized synchronous show-ahead FIFO for trace records
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data       : write request and record
//   pop                   : read request; ignored while empty
//   pop_data              : head entry, valid whenever empty is low
//   full, empty, count    : status; count ranges 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 75,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            // DEPTH is a power of two, so the pointers wrap by overflow.
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Clearing storage keeps the head output at zero after reset.
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - PC-triggered commit trace capture with FIFO drain
//
// Samples the processor debug outputs into {pc, opcode, wr_addr, wr_data}
// records once prog_count matches trigger_pc after an arm pulse, for
// capture_len samples (0 = unlimited), and drains them over trace_valid/ready.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   arm, trigger_pc, capture_len   : capture control
//   prog_count, instr_opcode,
//   write_reg_addr, write_reg_data : processor debug inputs
//   trace_valid, trace_ready,
//   trace_data                     : show-ahead record output
//   trace_state, fifo_count        : status
//   drop_count                     : saturating drop counter, only when
//                                    TRACE_DROP_COUNT_EN is defined
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16,
    localparam int REC_W    = 2 * WORD_SIZE + 11,
    localparam int FCW      = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic [WORD_SIZE-1:0] trigger_pc,
    input  logic [CNT_W-1:0]     capture_len,
    input  logic [WORD_SIZE-1:0] prog_count,
    input  logic [5:0]           instr_opcode,
    input  logic [4:0]           write_reg_addr,
    input  logic [WORD_SIZE-1:0] write_reg_data,
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [REC_W-1:0]     trace_data,
    output logic [1:0]           trace_state,
    output logic [FCW-1:0]       fifo_count
`ifdef TRACE_DROP_COUNT_EN
    ,
    output logic [CNT_W-1:0]     drop_count
`endif
);

    trace_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             attempt;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] record;

    assign record  = {prog_count, instr_opcode, write_reg_addr, write_reg_data};
    assign pop     = trace_valid && trace_ready;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        attempt = 1'b0;
        if (arm) begin
            // arm wins over a coincident trigger and takes no sample.
            state_d = TRACE_ARMED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                TRACE_ARMED: begin
                    if (prog_count == trigger_pc) begin
                        attempt = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = (capture_len == CNT_W'(1)) ? TRACE_DONE : TRACE_CAPTURE;
                    end
                end
                TRACE_CAPTURE: begin
                    attempt = 1'b1;
                    cnt_d   = cnt_inc;
                    // capture_len == 0 never terminates; the counter may wrap.
                    if ((capture_len != '0) && (cnt_inc == capture_len)) begin
                        state_d = TRACE_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TRACE_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TRACE_DROP_COUNT_EN
    logic [CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (arm) begin
            drop_d = '0;
        end else if (attempt && fifo_full && !pop && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;
`endif

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (attempt),
        .push_data (record),
        .pop       (pop),
        .pop_data  (trace_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign trace_valid = !fifo_empty;
    assign trace_state = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - self-checking bench for commit_trace_buffer against a queue-based reference model
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    localparam int W      = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int REC_W  = 2 * W + 11;
    localparam int FCW    = $clog2(DEPTH) + 1;
    localparam int PC_LSB = trace_pc_lsb(W);

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic [W-1:0]     trigger_pc;
    logic [CNT_W-1:0] capture_len;
    logic [W-1:0]     prog_count;
    logic [5:0]       instr_opcode;
    logic [4:0]       write_reg_addr;
    logic [W-1:0]     write_reg_data;
    logic             trace_valid;
    logic             trace_ready;
    logic [REC_W-1:0] trace_data;
    logic [1:0]       trace_state;
    logic [FCW-1:0]   fifo_count;
`ifdef TRACE_DROP_COUNT_EN
    logic [CNT_W-1:0] drop_count;
`endif

    commit_trace_buffer #(.WORD_SIZE(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .trigger_pc     (trigger_pc),
        .capture_len    (capture_len),
        .prog_count     (prog_count),
        .instr_opcode   (instr_opcode),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_data     (trace_data),
        .trace_state    (trace_state),
        .fifo_count     (fifo_count)
`ifdef TRACE_DROP_COUNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: capture phase, samples taken, drops, and the FIFO as a queue.
    int               m_phase;   // 0 idle, 1 armed, 2 capturing, 3 done
    int               m_taken;
    int               m_drop;
    logic [REC_W-1:0] m_q [$];
    logic [W-1:0]     log_pc [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit attempt;
        bit popped;
        attempt = 0;
        if (rst) begin
            m_phase = 0; m_taken = 0; m_drop = 0; m_q.delete();
            return;
        end
        popped = (m_q.size() > 0) && trace_ready;
        if (arm) begin
            m_phase = 1; m_taken = 0; m_drop = 0;
        end else if (m_phase == 1 && prog_count == trigger_pc) begin
            attempt = 1;
            m_taken = 1;
            m_phase = (capture_len == 1) ? 3 : 2;
        end else if (m_phase == 2) begin
            attempt = 1;
            m_taken++;
            if (capture_len != 0 && m_taken == int'(capture_len)) m_phase = 3;
        end
        if (popped) void'(m_q.pop_front());
        if (attempt) begin
            if (m_q.size() < DEPTH)
                m_q.push_back({prog_count, instr_opcode, write_reg_addr, write_reg_data});
            else if (m_drop < (1 << CNT_W) - 1)
                m_drop++;
        end
    endtask

    task automatic cyc();
        if (trace_valid && trace_ready) log_pc.push_back(trace_data[PC_LSB +: W]);
        model_step();
        @(posedge clk);
        #1;
        arm            = 1'b0;
        instr_opcode   = 6'($urandom);
        write_reg_addr = 5'($urandom);
        write_reg_data = $urandom;
        chk("state", 128'(trace_state), 128'(m_phase));
        chk("fifo_count", 128'(fifo_count), 128'(m_q.size()));
        chk("trace_valid", 128'(trace_valid), 128'(m_q.size() != 0));
        if (m_q.size() != 0) chk("head", 128'(trace_data), 128'(m_q[0]));
`ifdef TRACE_DROP_COUNT_EN
        chk("drop_count", 128'(drop_count), 128'(m_drop));
`endif
    endtask

    // Random PC that never equals an (even) trigger value.
    function automatic logic [W-1:0] rnd_pc();
        return $urandom | 32'h1;
    endfunction

    initial begin
        int d;
        rst = 1'b1; arm = 1'b0; trigger_pc = '0; capture_len = '0;
        prog_count = '0; instr_opcode = '0; write_reg_addr = '0; write_reg_data = '0;
        trace_ready = 1'b0;
        m_phase = 0; m_taken = 0; m_drop = 0;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_data", 128'(trace_data), 128'(0));
        chk("reset_state", 128'(trace_state), 128'(TRACE_IDLE));
        chk("reset_count", 128'(fifo_count), 128'(0));

        // Trigger and drain: three records 0x8, 0xC, 0x10.
        trigger_pc = 32'h8; capture_len = 3; trace_ready = 1'b1;
        arm = 1'b1; prog_count = rnd_pc(); cyc();
        log_pc.delete();
        for (int i = 0; i < 6; i++) begin
            prog_count = 32'(4 * i);
            cyc();
        end
        prog_count = rnd_pc();
        for (int i = 0; i < 3; i++) cyc();
        chk("t1_records", 128'(log_pc.size()), 128'(3));
        if (log_pc.size() == 3) begin
            chk("t1_pc0", 128'(log_pc[0]), 128'(32'h8));
            chk("t1_pc1", 128'(log_pc[1]), 128'(32'hC));
            chk("t1_pc2", 128'(log_pc[2]), 128'(32'h10));
        end
        chk("t1_done", 128'(trace_state), 128'(TRACE_DONE));
        chk("t1_empty", 128'(fifo_count), 128'(0));

        // Overflow with drops: 20 samples into a 16-deep FIFO.
        trigger_pc = 32'h100; capture_len = 20; trace_ready = 1'b0;
        arm = 1'b1; prog_count = rnd_pc(); cyc();
        for (int i = 0; i < 25; i++) begin
            prog_count = 32'h100 + 32'(4 * i);
            cyc();
        end
        chk("t2_full", 128'(fifo_count), 128'(16));
`ifdef TRACE_DROP_COUNT_EN
        chk("t2_drops", 128'(drop_count), 128'(4));
`endif
        log_pc.delete();
        trace_ready = 1'b1; prog_count = rnd_pc();
        for (int i = 0; i < 18; i++) cyc();
        chk("t2_drained", 128'(log_pc.size()), 128'(16));
        for (int i = 0; i < 16 && i < log_pc.size(); i++)
            chk("t2_pc", 128'(log_pc[i]), 128'(32'h100 + 32'(4 * i)));

        // Full FIFO with push+pop, unlimited capture, then arm on a trigger match.
        trigger_pc = 32'h200; capture_len = 0; trace_ready = 1'b0;
        arm = 1'b1; prog_count = rnd_pc(); cyc();
        prog_count = 32'h200; cyc();
        for (int i = 0; i < 19; i++) begin
            prog_count = rnd_pc();
            cyc();
        end
        chk("t3_full", 128'(fifo_count), 128'(16));
        d = m_drop;
        trace_ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("t3_still_full", 128'(fifo_count), 128'(16));
`ifdef TRACE_DROP_COUNT_EN
        chk("t3_no_new_drops", 128'(drop_count), 128'(d));
`endif
        for (int i = 0; i < 80; i++) begin
            trace_ready = 1'($urandom_range(0, 1));
            prog_count  = rnd_pc();
            cyc();
        end
        chk("t3_unlimited", 128'(trace_state), 128'(TRACE_CAPTURE));
        trace_ready = 1'b0; prog_count = 32'h200; arm = 1'b1; cyc();
        chk("t3_rearm", 128'(trace_state), 128'(TRACE_ARMED));
        chk("t3_kept", 128'(fifo_count), 128'(16));

        // Random-length capture with random back-pressure.
        trace_ready = 1'b1; prog_count = rnd_pc();
        for (int i = 0; i < 18; i++) cyc();
        trigger_pc = 32'h400; capture_len = CNT_W'($urandom_range(5, 30));
        arm = 1'b1; cyc();
        prog_count = 32'h400; cyc();
        for (int i = 0; i < 40; i++) begin
            trace_ready = 1'($urandom_range(0, 1));
            prog_count  = rnd_pc();
            cyc();
        end
        trace_ready = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk("t5_done", 128'(trace_state), 128'(TRACE_DONE));

        // Reset mid-capture with five entries buffered.
        trigger_pc = 32'h300; capture_len = 0; trace_ready = 1'b0;
        arm = 1'b1; prog_count = rnd_pc(); cyc();
        prog_count = 32'h300; cyc();
        for (int i = 0; i < 4; i++) begin
            prog_count = rnd_pc();
            cyc();
        end
        chk("t4_five", 128'(fifo_count), 128'(5));
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("t4_rst_count", 128'(fifo_count), 128'(0));
        chk("t4_rst_valid", 128'(trace_valid), 128'(0));
        chk("t4_rst_state", 128'(trace_state), 128'(TRACE_IDLE));
        prog_count = 32'h300;
        for (int i = 0; i < 3; i++) cyc();
        chk("t4_no_capture", 128'(fifo_count), 128'(0));
        chk("t4_idle", 128'(trace_state), 128'(TRACE_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Downstream debug consumer of the single-cycle `processor`. Each cycle it samples the processor's debug outputs (program counter, opcode, write-register address and data) into a trace record. Capture starts on a PC-match trigger and runs for a programmable length. Records are buffered in a synchronous FIFO and drained over a valid/ready interface toward a host/UART dumper.

## Interface
Parameters:
- `WORD_SIZE`, 32: datapath width; must match `processor`.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the capture-length and drop counters.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `arm` in 1: one-cycle pulse; (re)arms the trigger.
- `trigger_pc` in `WORD_SIZE`: PC value that starts capture.
- `capture_len` in `CNT_W`: number of samples to take from the trigger onward; 0 means unlimited.
- `prog_count` in `WORD_SIZE`: from `processor`.
- `instr_opcode` in 6: from `processor`.
- `write_reg_addr` in 5: from `processor`.
- `write_reg_data` in `WORD_SIZE`: from `processor`.
- `trace_valid` out 1: head record available.
- `trace_ready` in 1: consumer accepts head record.
- `trace_data` out 2·`WORD_SIZE`+11: head record, packed as {pc, opcode, wr_addr, wr_data}, with wr_data in the LSBs.
- `trace_state` out 2: FSM state.
- `fifo_count` out clog2(`DEPTH`)+1: current occupancy.
- `drop_count` out `CNT_W`: present only with `TRACE_DROP_COUNT_EN`.

## Operation
- FSM states:
  - IDLE = 0: no capture.
  - ARMED = 1: waiting for the trigger.
  - CAPTURE = 2: sampling every cycle.
  - DONE = 3: capture finished.
- Sample attempt: a cycle in which a record is offered to the FIFO.
- `arm` moves any state to ARMED and clears the sample counter and `drop_count`. The FIFO is **not** flushed. No sample is taken in an `arm` cycle; `arm` has priority over the trigger.
- ARMED:
  - When `prog_count == trigger_pc`, take a sample attempt of the current inputs and go to CAPTURE.
  - If `capture_len == 1`, go to DONE instead.
- CAPTURE:
  - One sample attempt per cycle; the counter increments per attempt, whether accepted or dropped.
  - When the counter reaches `capture_len` (counting the trigger sample), the final attempt occurs and the FSM goes to DONE.
  - With `capture_len == 0`, the FSM stays in CAPTURE until `arm` or `rst`.
- DONE: holds; only `arm` leaves it.
- FIFO push and pop:
  - A push is accepted when FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the record is dropped; `drop_count` increments and saturates at 2^`CNT_W`−1.
  - A pop occurs when `trace_valid && trace_ready`.
  - `trace_valid = (fifo_count != 0)`.
  - `trace_data` is show-ahead (head entry); its value is undefined-but-stable while `trace_valid` is low.
- Simultaneous push and pop on an empty FIFO: the pop is ignored because `trace_valid` is low, and the push is accepted.
- Pointers wrap modulo `DEPTH`. `fifo_count` ranges from 0 to `DEPTH`.

## Timing
- Reset values:
  - `trace_state` = IDLE.
  - `fifo_count` = 0.
  - `trace_valid` = 0.
  - `trace_data` = 0.
  - `drop_count` = 0.
  - Sample counter = 0.
- `rst` asserted mid-capture discards all FIFO contents and returns the block to IDLE on the next edge.
- A sample attempt at edge N (inputs captured) makes the record visible with `trace_valid` = 1 in cycle N+1 when the FIFO was empty. Latency is 1 cycle.
- A pop at edge N presents the next entry in cycle N+1. Sustained throughput is 1 record per cycle.
- Trigger compare is combinational on the current-cycle inputs; there is no registered lookahead.
- `trace_state` reflects the registered state; the transition to DONE is visible the cycle after the last attempt.

## Configuration
- `TRACE_DROP_COUNT_EN` defined: the `drop_count` port and its saturating counter exist.
- Undefined: the port is absent and dropped records are silently discarded. All other behaviour is identical.

## Structure
- Shared constants go in `cpu_constant_library.v`:
  - `TRACE_IDLE`, `TRACE_ARMED`, `TRACE_CAPTURE`, `TRACE_DONE` (2-bit).
  - Record field offsets `TRACE_DATA_LSB`, `TRACE_ADDR_LSB`, `TRACE_OP_LSB`, `TRACE_PC_LSB`.
- One sub-module, `trace_fifo`:
  - Parameterized width/depth synchronous show-ahead FIFO.
  - Ports: push, pop, full, empty, count.
- The FSM, counters and drop logic live in the top.

## Test plan
- Trigger and drain: `rst`; `arm`; `trigger_pc` = 0x8, `capture_len` = 3, PC sequence 0,4,8,C,10,14, `trace_ready` = 1 → exactly three records, with PCs 0x8, 0xC, 0x10, in order; `trace_state` = DONE; `fifo_count` returns to 0.
- Overflow with drops: `DEPTH` = 16, `capture_len` = 20, `trace_ready` = 0 → `fifo_count` = 16 and `drop_count` = 4 (with macro). Draining yields PCs for samples 1–16 only.
- Full push+pop: FIFO full, `trace_ready` = 1 while capture continues → `fifo_count` stays 16 and `drop_count` does not increment.
- Unlimited capture and re-arm: `capture_len` = 0 → the FSM stays in CAPTURE for 100 cycles. An `arm` pulse coinciding with a trigger match → ARMED with no sample that cycle; the FIFO keeps its old entries.
- Reset mid-capture: `rst` asserted with 5 entries buffered → next cycle `fifo_count` = 0, `trace_valid` = 0, IDLE. A trigger match afterwards without `arm` → no capture.
